conv_feed_controller: RTL and testbench

- Sequencer directly upstream of the 3x3 weight-stationary systolic array.
- Holds a 4x4 input feature map (FM) in a local buffer.
- Issues the one-cycle weight-load strobe, then streams four 3x3 windows into row1_in/row2_in/row3_in with the required skew.
- Drives the array's A/Acc enables and the result-demux/capture controls, so that c11, c12, c21 and c22 receive the four 2x2 convolution outputs.

---
 rtl/conv_feed_controller_pkg.sv | 22 ++
 rtl/conv_feed_controller_if.sv | 35 +++
 rtl/conv_feed_controller_fm_buffer.sv | 34 +++
 rtl/conv_feed_controller.sv | 113 +++++++++++
 tb/tb_conv_feed_controller.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_feed_controller_pkg.sv
// Shared types and constants for the systolic-array feed sequencer.
package conv_feed_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD_W = 2'd1,
        ST_FEED   = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam int FM_DIM = 4;
    localparam int K_DIM  = 3;

    // Window origins for w = 0..3, bit w selects the row/column offset.
    localparam logic [3:0] WIN_R = 4'b1100;
    localparam logic [3:0] WIN_C = 4'b1010;

    function automatic logic [3:0] fm_addr(input logic [1:0] row, input logic [1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/conv_feed_controller_if.sv
// Handshake, FM write port and array-control bundle of the feed sequencer.
interface conv_feed_controller_if #(
    parameter int DW = 8
);
    logic          wr_en;
    logic [3:0]    wr_addr;
    logic [DW-1:0] wr_data;
    logic          start;
    logic          busy;
    logic          done;
    logic          en_reg_A;
    logic [8:0]    en_reg_B;
    logic          en_reg_Acc;
    logic [DW-1:0] row1_in;
    logic [DW-1:0] row2_in;
    logic [DW-1:0] row3_in;
    logic [1:0]    sel_en_demux_result;
    logic [1:0]    sel_en_demux_c_reg;
    logic          input_demux_c_reg;

    modport master (
        output wr_en, wr_addr, wr_data, start,
        input  busy, done, en_reg_A, en_reg_B, en_reg_Acc,
        input  row1_in, row2_in, row3_in,
        input  sel_en_demux_result, sel_en_demux_c_reg, input_demux_c_reg
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start,
        output busy, done, en_reg_A, en_reg_B, en_reg_Acc,
        output row1_in, row2_in, row3_in,
        output sel_en_demux_result, sel_en_demux_c_reg, input_demux_c_reg
    );

endinterface

// File: rtl/conv_feed_controller_fm_buffer.sv
// 4x4 feature-map register file: one synchronous write port, three
// combinational read ports, asynchronous active-low clear.
module fm_buffer_4x4
    import conv_feed_controller_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       wr_en_i,
    input  logic [3:0]                 wr_addr_i,
    input  logic [DW-1:0]              wr_data_i,
    input  logic [K_DIM-1:0][3:0]      rd_addr_i,
    output logic [K_DIM-1:0][DW-1:0]   rd_data_o
);

    logic [FM_DIM*FM_DIM-1:0][DW-1:0] mem_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q <= '0;
        end else if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_comb begin
        rd_data_o = '0;
        for (int unsigned i = 0; i < K_DIM; i++) begin
            rd_data_o[i] = mem_q[rd_addr_i[i]];
        end
    end

endmodule

// File: rtl/conv_feed_controller.sv
// Weight-load then skewed 3x3-window feed for a 3x3 weight-stationary array,
// producing the four 2x2 convolution outputs with per-window capture control.
module conv_feed_controller
    import conv_feed_controller_pkg::*;
#(
    parameter int DW         = 8,
    parameter int CAPTURE_AT = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    conv_feed_controller_if.slave   bus
);

    localparam logic [2:0] K_LAST = 3'(CAPTURE_AT);

    state_e                     state_q, state_d;
    logic [2:0]                 k_q, k_d;
    logic [1:0]                 w_q, w_d;
    logic [K_DIM-1:0][3:0]      rd_addr;
    logic [K_DIM-1:0]           rd_valid;
    logic [K_DIM-1:0][DW-1:0]   rd_data;
    logic [K_DIM-1:0][DW-1:0]   row_q, row_d;
    logic                       buf_we;

    assign buf_we = (state_q == ST_IDLE) && bus.wr_en;

    fm_buffer_4x4 #(
        .DW(DW)
    ) u_fm_buffer (
        .clk_i     (clk),
        .rst_ni    (rst),
        .wr_en_i   (buf_we),
        .wr_addr_i (bus.wr_addr),
        .wr_data_i (bus.wr_data),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            w_q     <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            w_q     <= w_d;
            row_q   <= row_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = '0;
        w_d     = '0;
        unique case (state_q)
            ST_IDLE:   if (bus.start) state_d = ST_LOAD_W;
            ST_LOAD_W: state_d = ST_FEED;
            ST_FEED: begin
                w_d = w_q;
                k_d = k_q + 3'd1;
                if (k_q == K_LAST) begin
                    k_d = '0;
                    if (w_q == 2'd3) begin
                        state_d = ST_DONE;
                        w_d     = '0;
                    end else begin
                        w_d = w_q + 2'd1;
                    end
                end
            end
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Addresses come from the next-state slot so the registered row value
    // lines up with the slot it belongs to; columns run right-to-left.
    always_comb begin
        rd_addr  = '0;
        rd_valid = '0;
        for (int unsigned i = 0; i < K_DIM; i++) begin
            if (state_d == ST_FEED && k_d >= 3'(i) && (k_d - 3'(i)) <= 3'd2) begin
                rd_valid[i] = 1'b1;
                rd_addr[i]  = fm_addr({1'b0, WIN_R[w_d]} + 2'(i),
                                      {1'b0, WIN_C[w_d]} + 2'd2 - 2'(k_d - 3'(i)));
            end
        end
    end

    always_comb begin
        row_d = '0;
        for (int unsigned i = 0; i < K_DIM; i++) begin
            row_d[i] = rd_valid[i] ? rd_data[i] : '0;
        end
    end

    always_comb begin
        bus.busy                = (state_q != ST_IDLE);
        bus.done                = (state_q == ST_DONE);
        bus.en_reg_B            = (state_q == ST_LOAD_W) ? '1 : '0;
        bus.en_reg_A            = (state_q == ST_FEED);
        bus.en_reg_Acc          = (state_q == ST_FEED);
        bus.sel_en_demux_result = (state_q == ST_FEED) ? w_q : '0;
        bus.sel_en_demux_c_reg  = (state_q == ST_FEED) ? w_q : '0;
        bus.input_demux_c_reg   = (state_q == ST_FEED) && (k_q == K_LAST);
        bus.row1_in             = row_q[0];
        bus.row2_in             = row_q[1];
        bus.row3_in             = row_q[2];
    end

endmodule

// File: tb/tb_conv_feed_controller.sv
// Randomized self-checking bench for conv_feed_controller against a
// cycle-indexed behavioural model of the feed schedule.
module tb_conv_feed_controller;

    localparam int DW   = 8;
    localparam int CAP  = 6;
    localparam int SLOT = CAP + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    conv_feed_controller_if #(.DW(DW)) bus();

    conv_feed_controller #(
        .DW         (DW),
        .CAPTURE_AT (CAP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] fm [16];
    logic [41:0]   all_out;

    assign all_out = {bus.busy, bus.done, bus.en_reg_A, bus.en_reg_B, bus.en_reg_Acc,
                      bus.row1_in, bus.row2_in, bus.row3_in,
                      bus.sel_en_demux_result, bus.sel_en_demux_c_reg, bus.input_demux_c_reg};

    // Pixel a window row should present at slot k: reversed columns, skewed by row.
    function automatic logic [DW-1:0] exp_row(input int w, input int k, input int i);
        int r, c, d;
        r = w / 2;
        c = w % 2;
        d = k - i;
        if (d < 0 || d > 2) return '0;
        return fm[(r + i) * 4 + (c + 2 - d)];
    endfunction

    task automatic load_fm(input bit randomize_fill);
        for (int a = 0; a < 16; a++) begin
            @(negedge clk);
            fm[a] = randomize_fill ? DW'($urandom_range(0, 255)) : DW'(a + 1);
            bus.wr_en   = 1'b1;
            bus.wr_addr = 4'(a);
            bus.wr_data = fm[a];
        end
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0", all_out);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL post_reset_outputs got %h want 0", all_out);
        end
    endtask

    task automatic test_full_run(input bit disturb, input string name);
        int caps;
        caps = 0;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int n = 1; n <= 32; n++) begin
            bit feed;
            int idx, w, k;
            logic e_busy, e_done, e_cap;
            logic [8:0] e_b;
            logic [1:0] e_sel;
            logic [DW-1:0] e_r1, e_r2, e_r3;
            if (n > 1) @(negedge clk);
            feed   = (n >= 2) && (n <= 1 + 4 * SLOT);
            idx    = n - 2;
            w      = feed ? idx / SLOT : 0;
            k      = feed ? idx % SLOT : 0;
            e_busy = (n <= 2 + 4 * SLOT);
            e_done = (n == 2 + 4 * SLOT);
            e_b    = (n == 1) ? 9'h1FF : 9'h000;
            e_sel  = feed ? 2'(w) : 2'd0;
            e_cap  = feed && (k == CAP);
            e_r1   = feed ? exp_row(w, k, 0) : '0;
            e_r2   = feed ? exp_row(w, k, 1) : '0;
            e_r3   = feed ? exp_row(w, k, 2) : '0;

            checks++;
            if (bus.busy !== e_busy) begin
                errors++;
                $display("FAIL %s busy n=%0d got %b want %b", name, n, bus.busy, e_busy);
            end
            checks++;
            if (bus.done !== e_done) begin
                errors++;
                $display("FAIL %s done n=%0d got %b want %b", name, n, bus.done, e_done);
            end
            checks++;
            if (bus.en_reg_B !== e_b) begin
                errors++;
                $display("FAIL %s en_reg_B n=%0d got %h want %h", name, n, bus.en_reg_B, e_b);
            end
            checks++;
            if (bus.en_reg_A !== feed) begin
                errors++;
                $display("FAIL %s en_reg_A n=%0d got %b want %b", name, n, bus.en_reg_A, feed);
            end
            checks++;
            if (bus.en_reg_Acc !== feed) begin
                errors++;
                $display("FAIL %s en_reg_Acc n=%0d got %b want %b", name, n, bus.en_reg_Acc, feed);
            end
            checks++;
            if (bus.input_demux_c_reg !== e_cap) begin
                errors++;
                $display("FAIL %s capture n=%0d got %b want %b", name, n, bus.input_demux_c_reg, e_cap);
            end
            checks++;
            if (bus.sel_en_demux_result !== e_sel || bus.sel_en_demux_c_reg !== e_sel) begin
                errors++;
                $display("FAIL %s selects n=%0d got %0d/%0d want %0d", name, n,
                         bus.sel_en_demux_result, bus.sel_en_demux_c_reg, e_sel);
            end
            checks++;
            if (bus.row1_in !== e_r1) begin
                errors++;
                $display("FAIL %s row1 n=%0d w=%0d k=%0d got %0d want %0d", name, n, w, k, bus.row1_in, e_r1);
            end
            checks++;
            if (bus.row2_in !== e_r2) begin
                errors++;
                $display("FAIL %s row2 n=%0d w=%0d k=%0d got %0d want %0d", name, n, w, k, bus.row2_in, e_r2);
            end
            checks++;
            if (bus.row3_in !== e_r3) begin
                errors++;
                $display("FAIL %s row3 n=%0d w=%0d k=%0d got %0d want %0d", name, n, w, k, bus.row3_in, e_r3);
            end
            if (bus.input_demux_c_reg === 1'b1) caps++;

            if (disturb) begin
                if (n == 10) begin
                    bus.start   = 1'b1;
                    bus.wr_en   = 1'b1;
                    bus.wr_addr = 4'd0;
                    bus.wr_data = 8'hFF;
                end else if (n == 2 + 4 * SLOT) begin
                    bus.start = 1'b1;
                    bus.wr_en = 1'b0;
                end else begin
                    bus.start = 1'b0;
                    bus.wr_en = 1'b0;
                end
            end
        end
        checks++;
        if (caps != 4) begin
            errors++;
            $display("FAIL %s capture_count got %0d want 4", name, caps);
        end
    endtask

    task automatic test_pattern();
        load_fm(1'b0);
        test_full_run(1'b0, "pattern");
    endtask

    task automatic test_illegal_while_busy();
        test_full_run(1'b1, "illegal_busy");
        test_full_run(1'b0, "replay");
    endtask

    task automatic test_reset_mid_feed();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (11) @(negedge clk);
        checks++;
        if (bus.sel_en_demux_result !== 2'd1 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL midreset_position sel got %0d busy %b want 1/1",
                     bus.sel_en_demux_result, bus.busy);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL midreset_outputs got %h want 0", all_out);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int a = 0; a < 16; a++) fm[a] = '0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL midreset_quiet n=%0d done %b busy %b want 0/0", n, bus.done, bus.busy);
            end
        end
        test_full_run(1'b0, "cleared_buffer");
    endtask

    task automatic test_random_runs();
        for (int r = 0; r < 3; r++) begin
            load_fm(1'b1);
            test_full_run(r == 1, "random");
        end
    endtask

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.start   = 1'b0;
        for (int a = 0; a < 16; a++) fm[a] = '0;
        test_reset();
        test_pattern();
        test_illegal_while_busy();
        test_reset_mid_feed();
        test_random_runs();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
